// File: rtl/udp_rx_port_demux_pkg.sv
// Shared types for the UDP RX port demultiplexer: decoded header layout and FSM states.
package udp_pkg;

    localparam int unsigned UDP_HDR_W = 336;

    typedef struct packed {
        logic [47:0] eth_dest_mac;
        logic [47:0] eth_src_mac;
        logic [15:0] eth_type;
        logic [3:0]  ip_version;
        logic [3:0]  ip_ihl;
        logic [5:0]  ip_dscp;
        logic [1:0]  ip_ecn;
        logic [15:0] ip_length;
        logic [15:0] ip_identification;
        logic [2:0]  ip_flags;
        logic [12:0] ip_fragment_offset;
        logic [7:0]  ip_ttl;
        logic [7:0]  ip_protocol;
        logic [15:0] ip_header_checksum;
        logic [31:0] ip_source_ip;
        logic [31:0] ip_dest_ip;
        logic [15:0] udp_source_port;
        logic [15:0] udp_dest_port;
        logic [15:0] udp_length;
        logic [15:0] udp_checksum;
    } udp_hdr_t;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} demux_state_t;

    // Channel index width; a single channel still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/udp_rx_port_demux_if.sv
// Header + payload stream bundle; NUM_LANES > 1 gives per-channel valid/ready vectors.
interface udp_rx_port_demux_if
    import udp_pkg::*;
#(
    parameter int unsigned NUM_LANES  = 1,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [NUM_LANES-1:0]  hdr_valid;
    logic [NUM_LANES-1:0]  hdr_ready;
    udp_hdr_t              hdr;
    logic [DATA_WIDTH-1:0] tdata;
    logic [NUM_LANES-1:0]  tvalid;
    logic [NUM_LANES-1:0]  tready;
    logic                  tlast;

    modport master (output hdr_valid, hdr, tdata, tvalid, tlast, input hdr_ready, tready);
    modport slave  (input hdr_valid, hdr, tdata, tvalid, tlast, output hdr_ready, tready);
endinterface

// File: rtl/udp_rx_port_demux_match.sv
// Destination-port lookup: parallel compare against the port table, lowest index wins.
module udp_port_match
    import udp_pkg::*;
#(
    parameter int unsigned N_CHANNELS = 4,
    parameter logic [15:0] PORT_TABLE [N_CHANNELS] = '{16'd5000, 16'd5001, 16'd5002, 16'd5003}
) (
    input  logic [15:0]                        dest_port,
    output logic                               hit,
    output logic [idx_width(N_CHANNELS)-1:0]   idx
);
    localparam int unsigned IdxW = idx_width(N_CHANNELS);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        // Scan downwards so the lowest matching index is the last one written.
        for (int i = N_CHANNELS - 1; i >= 0; i--) begin
            if (dest_port == PORT_TABLE[i]) begin
                hit = 1'b1;
                idx = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/udp_rx_port_demux.sv
// Steers one UDP header + payload at a time to the channel owning its destination port.
module udp_rx_port_demux
    import udp_pkg::*;
#(
    parameter int unsigned N_CHANNELS     = 4,
    parameter logic [15:0] PORT_TABLE [N_CHANNELS] = '{16'd5000, 16'd5001, 16'd5002, 16'd5003},
    parameter int unsigned DATA_WIDTH     = 8,
    parameter bit          DROP_UNMATCHED = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    udp_rx_port_demux_if.slave  s_bus,
    udp_rx_port_demux_if.master m_bus,
    output logic [31:0]         drop_count
);
    localparam int unsigned IdxW = idx_width(N_CHANNELS);

    demux_state_t          state_q, state_d;
    logic [IdxW-1:0]       sel_q, sel_d;
    udp_hdr_t              m_hdr_q, m_hdr_d;
    logic [31:0]           drop_count_q, drop_count_d;

    logic                  hit;
    logic [IdxW-1:0]       idx;
    logic [N_CHANNELS-1:0] sel_onehot;
    logic                  s_hdr_ready, s_tready;
    logic [N_CHANNELS-1:0] m_hdr_valid, m_tvalid;

    udp_port_match #(
        .N_CHANNELS (N_CHANNELS),
        .PORT_TABLE (PORT_TABLE)
    ) u_match (
        .dest_port (s_bus.hdr.udp_dest_port),
        .hit       (hit),
        .idx       (idx)
    );

    assign sel_onehot = N_CHANNELS'(1) << sel_q;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        m_hdr_d      = m_hdr_q;
        drop_count_d = drop_count_q;
        s_hdr_ready  = 1'b0;
        s_tready     = 1'b0;
        m_hdr_valid  = '0;
        m_tvalid     = '0;
        unique case (state_q)
            IDLE: begin
                s_hdr_ready = 1'b1;
                if (s_bus.hdr_valid[0]) begin
                    m_hdr_d = s_bus.hdr;
                    if (hit) begin
                        sel_d   = idx;
                        state_d = HDR;
                    end else if (!DROP_UNMATCHED) begin
                        sel_d   = IdxW'(N_CHANNELS - 1);
                        state_d = HDR;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            HDR: begin
                m_hdr_valid = sel_onehot;
                if (m_bus.hdr_ready[sel_q]) state_d = PAYLOAD;
            end
            PAYLOAD: begin
                m_tvalid = sel_onehot & {N_CHANNELS{s_bus.tvalid[0]}};
                s_tready = m_bus.tready[sel_q];
                if (s_bus.tvalid[0] && s_tready && s_bus.tlast) state_d = IDLE;
            end
            DROP: begin
                s_tready = 1'b1;
                if (s_bus.tvalid[0] && s_bus.tlast) begin
                    if (drop_count_q != 32'hFFFF_FFFF) drop_count_d = drop_count_q + 32'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // No handshake may complete in a reset cycle, so leftover beats stay unconsumed.
        if (rst) begin
            s_hdr_ready = 1'b0;
            s_tready    = 1'b0;
            m_hdr_valid = '0;
            m_tvalid    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            m_hdr_q      <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            m_hdr_q      <= m_hdr_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign s_bus.hdr_ready[0] = s_hdr_ready;
    assign s_bus.tready[0]    = s_tready;
    assign m_bus.hdr_valid    = m_hdr_valid;
    assign m_bus.hdr          = m_hdr_q;
    assign m_bus.tdata        = s_bus.tdata;
    assign m_bus.tvalid       = m_tvalid;
    assign m_bus.tlast        = s_bus.tlast;
    assign drop_count         = drop_count_q;

endmodule

// File: tb/tb_udp_rx_port_demux.sv
// Directed plus randomized datagrams into two demux instances (drop / route-unmatched).
module tb_udp_rx_port_demux;
    import udp_pkg::*;

    typedef struct {
        int         d;
        int         ch;
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        int       d;
        int       ch;
        udp_hdr_t hdr;
    } hdr_rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       hv = 1'b0, tv = 1'b0, tl = 1'b0, sel_b = 1'b0;
    udp_hdr_t   hdr_in = '0;
    logic [7:0] td = '0;
    logic [3:0] hrdy = '0, trdy = '0;
    logic [31:0] dc_a, dc_b;

    int total = 0;
    int bad   = 0;
    int dc_model = 0;
    int tbl [2][4] = '{'{5000, 5001, 5002, 5003}, '{5000, 5001, 5001, 5003}};
    beat_t    rxq[$];
    hdr_rec_t hq[$];

    udp_rx_port_demux_if #(.NUM_LANES(1), .DATA_WIDTH(8)) sa ();
    udp_rx_port_demux_if #(.NUM_LANES(4), .DATA_WIDTH(8)) ma ();
    udp_rx_port_demux_if #(.NUM_LANES(1), .DATA_WIDTH(8)) sb ();
    udp_rx_port_demux_if #(.NUM_LANES(4), .DATA_WIDTH(8)) mb ();

    assign sa.hdr_valid = hv & ~sel_b;
    assign sb.hdr_valid = hv & sel_b;
    assign sa.hdr = hdr_in;
    assign sb.hdr = hdr_in;
    assign sa.tdata = td;
    assign sb.tdata = td;
    assign sa.tvalid = tv & ~sel_b;
    assign sb.tvalid = tv & sel_b;
    assign sa.tlast = tl;
    assign sb.tlast = tl;
    assign ma.hdr_ready = hrdy;
    assign mb.hdr_ready = hrdy;
    assign ma.tready = trdy;
    assign mb.tready = trdy;

    udp_rx_port_demux u_dut_a (
        .clk(clk), .rst(rst), .s_bus(sa), .m_bus(ma), .drop_count(dc_a)
    );

    udp_rx_port_demux #(
        .N_CHANNELS(4),
        .PORT_TABLE('{16'd5000, 16'd5001, 16'd5001, 16'd5003}),
        .DATA_WIDTH(8),
        .DROP_UNMATCHED(1'b0)
    ) u_dut_b (
        .clk(clk), .rst(rst), .s_bus(sb), .m_bus(mb), .drop_count(dc_b)
    );

    logic       s_hrdy_obs, s_trdy_obs;
    logic [3:0] mhv_obs;
    logic [UDP_HDR_W-1:0] mhdr_obs;
    assign s_hrdy_obs = sel_b ? sb.hdr_ready[0] : sa.hdr_ready[0];
    assign s_trdy_obs = sel_b ? sb.tready[0] : sa.tready[0];
    assign mhv_obs    = sel_b ? mb.hdr_valid : ma.hdr_valid;
    assign mhdr_obs   = sel_b ? mb.hdr : ma.hdr;

    task automatic check(input string tag, input logic [UDP_HDR_W-1:0] obs,
                         input logic [UDP_HDR_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_chan(input int d, input int port);
        for (int i = 0; i < 4; i++) if (tbl[d][i] == port) return i;
        return (d == 0) ? -1 : 3;
    endfunction

    // Output monitor: records every downstream handshake with its channel.
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            assert (($countones(ma.tvalid) <= 1) && ($countones(mb.tvalid) <= 1)) else begin
                bad++;
                $error("FAIL onehot_tvalid: got a=%b b=%b want at most one bit",
                       ma.tvalid, mb.tvalid);
            end
            for (int c = 0; c < 4; c++) begin
                if (ma.tvalid[c] && trdy[c]) rxq.push_back('{0, c, ma.tdata, ma.tlast});
                if (mb.tvalid[c] && trdy[c]) rxq.push_back('{1, c, mb.tdata, mb.tlast});
                if (ma.hdr_valid[c] && hrdy[c]) hq.push_back('{0, c, ma.hdr});
                if (mb.hdr_valid[c] && hrdy[c]) hq.push_back('{1, c, mb.hdr});
            end
        end
    end

    task automatic run_dgram(input int d, input int port, input int nbeats, input int base,
                             input int hstall, input int mode, input int rst_beat);
        int ch, cyc, i, n_exp;
        logic [7:0] data[$];
        logic [UDP_HDR_W-1:0] raw;
        logic [3:0] oh;
        bit was_reset;
        was_reset = 1'b0;
        sel_b = (d == 1);
        ch = exp_chan(d, port);
        oh = (ch >= 0) ? 4'(1 << ch) : 4'b0000;
        raw = '0;
        for (int k = 0; k < 11; k++) raw = {raw[UDP_HDR_W-33:0], 32'($urandom)};
        hdr_in = raw;
        hdr_in.udp_dest_port = 16'(port);
        for (int k = 0; k < nbeats; k++) data.push_back((base != 0) ? 8'(base + k) : 8'($urandom));
        rxq.delete();
        hq.delete();
        hrdy = (hstall > 0) ? ~oh : 4'hF;
        trdy = 4'hF;
        hv = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!s_hrdy_obs && cyc < 20) begin @(negedge clk); cyc++; end
        check("hdr_accept", s_hrdy_obs, 1);
        @(posedge clk); #1;
        hv = 1'b0;
        check("hdr_latency", mhv_obs, oh);
        if (ch >= 0) begin
            check("hdr_data", mhdr_obs, hdr_in);
            tv = 1'b1; td = data[0]; tl = (nbeats == 1);
            for (int k = 0; k < hstall; k++) begin
                @(negedge clk);
                check("hdr_hold_valid", mhv_obs, oh);
                check("hdr_hold_data", mhdr_obs, hdr_in);
                check("hdr_stall_tready", s_trdy_obs, 0);
                @(posedge clk); #1;
            end
            hrdy = 4'hF;
            @(posedge clk); #1;
        end
        i = 0;
        cyc = 0;
        while (i < nbeats && cyc < 200) begin
            tv = 1'b1; td = data[i]; tl = (i == nbeats - 1);
            if (i == rst_beat) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check("rst_hdr_valid", {ma.hdr_valid, mb.hdr_valid}, 0);
                check("rst_tvalid", {ma.tvalid, mb.tvalid}, 0);
                check("rst_idle", s_hrdy_obs, 1);
                check("rst_no_consume", s_trdy_obs, 0);
                @(negedge clk);
                check("rst_no_consume2", s_trdy_obs, 0);
                dc_model = 0;
                was_reset = 1'b1;
                @(posedge clk); #1;
                break;
            end
            if (mode == 1) trdy = (cyc % 2 == 0) ? 4'hF : ~oh;
            else if (mode == 2) trdy = 4'($urandom);
            else trdy = 4'hF;
            @(negedge clk);
            check("busy_no_hdr", s_hrdy_obs, 0);
            if (ch < 0) check("drop_tready", s_trdy_obs, 1);
            if (s_trdy_obs) i++;
            @(posedge clk); #1;
            cyc++;
        end
        tv = 1'b0; tl = 1'b0; trdy = 4'hF;
        if (!was_reset) begin
            check("payload_done", i, nbeats);
            check("idle_after", s_hrdy_obs, 1);
            if (ch < 0) dc_model++;
        end
        n_exp = was_reset ? rst_beat : ((ch >= 0) ? nbeats : 0);
        check("beat_count", rxq.size(), n_exp);
        for (int k = 0; k < n_exp && k < rxq.size(); k++) begin
            check("beat_dut", rxq[k].d, d);
            check("beat_chan", rxq[k].ch, ch);
            check("beat_data", rxq[k].data, data[k]);
            check("beat_last", rxq[k].last, !was_reset && (k == nbeats - 1));
        end
        check("hdr_count", hq.size(), (ch >= 0) ? 1 : 0);
        if (ch >= 0 && hq.size() > 0) begin
            check("hdr_chan", hq[0].ch, ch);
            check("hdr_out", hq[0].hdr, hdr_in);
        end
        check("drop_count_a", dc_a, dc_model);
        check("drop_count_b", dc_b, 0);
    endtask

    initial begin
        int ports [6] = '{5000, 5001, 5002, 5003, 6000, 0};
        int p;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hdr_ready", {sa.hdr_ready, sb.hdr_ready}, 0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("reset_hdr_valid", {ma.hdr_valid, mb.hdr_valid}, 0);
        check("reset_tvalid", {ma.tvalid, mb.tvalid}, 0);
        check("reset_m_hdr", ma.hdr, 0);
        check("reset_drop_count", dc_a, 0);
        check("reset_tready", {sa.tready, sb.tready}, 0);
        check("reset_idle_ready", sa.hdr_ready, 1);

        run_dgram(0, 5001, 4, 8'h11, 0, 0, -1);
        run_dgram(0, 6000, 3, 0, 0, 0, -1);
        run_dgram(1, 6000, 3, 0, 0, 0, -1);
        run_dgram(0, 5002, 2, 0, 5, 0, -1);
        run_dgram(0, 5000, 6, 0, 0, 1, -1);
        run_dgram(0, 5000, 6, 0, 0, 0, 2);
        run_dgram(0, 5003, 2, 0, 0, 0, -1);
        run_dgram(0, 5000, 1, 0, 0, 0, -1);
        run_dgram(0, 5002, 1, 0, 0, 0, -1);
        run_dgram(0, 7000, 1, 0, 0, 0, -1);
        run_dgram(1, 5001, 2, 0, 1, 0, -1);
        run_dgram(1, 5002, 1, 0, 0, 0, -1);

        for (int n = 0; n < 25; n++) begin
            p = ports[$urandom_range(5, 0)];
            if (p == 0) p = int'($urandom_range(65535, 0));
            run_dgram(int'($urandom_range(1, 0)), p, int'($urandom_range(6, 1)), 0,
                      int'($urandom_range(3, 0)), int'($urandom_range(2, 0)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/udp_rx_port_demux.md
Name: udp_rx_port_demux

Overview:
- Receives one decoded UDP header plus its payload stream from the Ethernet-side UDP stack.
- Steers the header and payload to one of N FPGA-side channels by matching the UDP destination port against a parametrised port table.
- Unmatched datagrams are either dropped and counted, or sent to a default channel.
- Sits between the UDP RX stack and the application consumers. It generalises the single-consumer UDP output header path to many consumers.

Parameters:
- N_CHANNELS, 4, number of output channels (1..16).
- PORT_TABLE, {16'd5000, 16'd5001, 16'd5002, 16'd5003}, unpacked array [N_CHANNELS] of 16-bit destination ports. Channel i owns PORT_TABLE[i].
- DATA_WIDTH, 8, payload tdata width in bits.
- DROP_UNMATCHED, 1, 1 = discard unmatched datagrams; 0 = route them to channel N_CHANNELS-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- s_hdr_valid  in  1  input header valid.
- s_hdr_ready  out  1  input header ready.
- s_hdr  in  $bits(udp_hdr_t)  packed header: eth, ip and udp fields.
- s_axis_tdata  in  DATA_WIDTH  input payload data.
- s_axis_tvalid  in  1  input payload valid.
- s_axis_tready  out  1  input payload ready.
- s_axis_tlast  in  1  last payload beat.
- m_hdr_valid  out  N_CHANNELS  per-channel header valid.
- m_hdr_ready  in  N_CHANNELS  per-channel header ready.
- m_hdr  out  $bits(udp_hdr_t)  registered header, shared by all channels.
- m_axis_tdata  out  DATA_WIDTH  payload data, shared by all channels.
- m_axis_tvalid  out  N_CHANNELS  per-channel payload valid.
- m_axis_tready  in  N_CHANNELS  per-channel payload ready.
- m_axis_tlast  out  1  payload last, shared by all channels.
- drop_count  out  32  number of datagrams dropped as unmatched.

Behaviour:
- Clocking: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: state=IDLE; s_hdr_ready=0 during rst; m_hdr_valid=0; m_axis_tvalid=0; s_axis_tready=0; m_hdr=0; drop_count=0.
- IDLE:
  - s_hdr_ready=1.
  - On s_hdr_valid&s_hdr_ready: latch s_hdr into m_hdr and latch the match result sel.
  - Go to HDR if matched (or DROP_UNMATCHED=0); otherwise go to DROP.
- Match rule:
  - Compare s_hdr.udp_dest_port against every PORT_TABLE entry in the same cycle.
  - Duplicate entries resolve to the lowest index.
- HDR:
  - m_hdr_valid[sel]=1; all other bits 0.
  - m_hdr is held stable until m_hdr_ready[sel]; then go to PAYLOAD.
  - Header latency: m_hdr_valid rises 1 cycle after the input header handshake.
- PAYLOAD:
  - Combinational pass-through: m_axis_tvalid[sel]=s_axis_tvalid; s_axis_tready=m_axis_tready[sel]; tdata and tlast are forwarded.
  - Other channels see tvalid=0.
  - Go to IDLE on a handshake with tlast=1.
- DROP:
  - s_axis_tready=1; beats are discarded.
  - On a tlast handshake: drop_count increments (saturates at 32'hFFFF_FFFF), then go to IDLE.
- s_axis_tready=0 in IDLE and HDR. Payload is never consumed before its header has been delivered.
- One datagram in flight at a time. The next header is accepted the cycle after the state returns to IDLE, giving a minimum 1-cycle gap.
- A 1-beat payload (tlast on the first beat) is legal in both PAYLOAD and DROP.
- Downstream backpressure:
  - tready low on the selected channel stalls the input.
  - Ready on non-selected channels is ignored.
- Reset mid-packet:
  - Return to IDLE immediately; the datagram in flight is abandoned and no tlast is emitted downstream.
  - Leftover input beats after reset are not consumed until the next header.
- m_hdr_valid is never deasserted before its handshake.

Decomposition:
- Package udp_pkg holds:
  - typedef udp_hdr_t (packed struct): eth_dest_mac[48], eth_src_mac[48], eth_type[16].
  - IP fields: ip_version[4], ip_ihl[4], ip_dscp[6], ip_ecn[2], ip_length[16], ip_identification[16], ip_flags[3], ip_fragment_offset[13], ip_ttl[8], ip_protocol[8], ip_header_checksum[16], ip_source_ip[32], ip_dest_ip[32].
  - UDP fields: udp_source_port[16], udp_dest_port[16], udp_length[16], udp_checksum[16].
  - Total width 336 bits.
  - State enum demux_state_t {IDLE, HDR, PAYLOAD, DROP}.
  - Constant UDP_HDR_W=336.
- Sub-module udp_port_match: combinational compare plus priority encoder.
  - Parameters N_CHANNELS and PORT_TABLE.
  - Outputs: hit, and idx[$clog2(N_CHANNELS)].

Test Plan:
- Header dest_port=5001 with a 4-beat payload 0x11..0x14, all readies high -> m_hdr_valid=4'b0010 one cycle after the input handshake; channel 1 receives 0x11..0x14 with tlast on 0x14; drop_count=0.
- dest_port=6000, 3 beats, DROP_UNMATCHED=1 -> no m_hdr_valid; s_axis_tready=1 for 3 cycles; drop_count=1. Repeat with DROP_UNMATCHED=0 -> routed to channel 3.
- Match to channel 2 with m_hdr_ready[2] held low for 5 cycles -> m_hdr_valid[2] and m_hdr held stable for 5 cycles; s_axis_tready=0 throughout.
- PAYLOAD with m_axis_tready[0] toggling 1010 and other channels' ready=1 -> input stalls on the low cycles; no beats lost or duplicated; output order matches input.
- Assert rst during beat 2 of a 6-beat datagram to channel 0 -> all valids 0 the next cycle; state is IDLE; a following header to port 5003 routes correctly to channel 3.
- Back-to-back headers to 5000 then 5002 with 1-beat payloads -> second s_hdr_ready rises the cycle after the first tlast handshake; channel outputs are correct; drop_count stays 0.
